// File: rtl/pll_drp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_ctrl_if
// Brief    : Request/response handshake bundle between a client and pll_drp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_drp_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_commit;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_write, req_commit, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_commit, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_drp_ctrl
// Brief    : Single-register PLL DRP access controller; optional post-write PLL
//            reset and lock wait, enabled by macro PLL_DRP_LOCK_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pll_drp_ctrl #(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_STABLE  = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic         mdclk,
  input  logic         reset,
  pll_drp_ctrl_if.slave bus,
  output logic         busy,
  output logic [1:0]   mdopc,
  output logic         mdainc,
  output logic [7:0]   mdwdi,
  input  logic [7:0]   mdrdo,
  input  logic         lock,
  output logic         pll_reset
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ACCESS   = 3'd2,
    S_CAPTURE  = 3'd3,
    S_RST      = 3'd4,
    S_LOCKWAIT = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_ADDR  = 2'b11;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;

  state_t     r_state, w_state_nxt;
  logic       r_write;
  logic [7:0] r_addr, r_wdata;
  logic       r_ready, r_busy, r_rsp_valid;
  logic [1:0] r_opc, w_opc_nxt;
  logic [7:0] r_wdi, w_wdi_nxt;
  logic [7:0] r_rdata, w_rdata_nxt;
  logic       w_accept;

`ifdef PLL_DRP_LOCK_WAIT_EN
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE - 1);
  localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);

  logic        r_commit;
  logic        r_lock_meta, r_lock_sync;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_stable, w_stable_nxt;
  logic        r_err, w_timeout;
  logic        r_pll_reset;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
`ifdef PLL_DRP_LOCK_WAIT_EN
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (!r_write) begin
          w_state_nxt = S_CAPTURE;
        end
`ifdef PLL_DRP_LOCK_WAIT_EN
        else if (r_commit) begin
          w_state_nxt = S_RST;
          w_cnt_nxt   = '0;
        end
`endif
        else begin
          w_state_nxt = S_DONE;
        end
      end
      S_CAPTURE: w_state_nxt = S_DONE;
`ifdef PLL_DRP_LOCK_WAIT_EN
      S_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt  = S_LOCKWAIT;
          w_cnt_nxt    = '0;
          w_stable_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_LOCKWAIT: begin
        // Lock success wins over a timeout landing on the same cycle.
        if (r_lock_sync && (r_stable == STABLE_LAST)) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_DONE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_nxt    = r_cnt + 16'd1;
          w_stable_nxt = r_lock_sync ? (r_stable + 16'd1) : 16'd0;
        end
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values are computed for the state being entered so every port is a flop.
  always_comb begin
    w_opc_nxt   = OPC_NOP;
    w_wdi_nxt   = 8'h00;
    w_rdata_nxt = r_rdata;
    case (w_state_nxt)
      S_ADDR: begin
        w_opc_nxt = OPC_ADDR;
        w_wdi_nxt = bus.req_addr;
      end
      S_ACCESS: begin
        w_opc_nxt = r_write ? OPC_WRITE : OPC_READ;
        w_wdi_nxt = r_write ? r_wdata : 8'h00;
      end
      S_DONE:  w_rdata_nxt = (r_state == S_CAPTURE) ? mdrdo : 8'h00;
      default: ;
    endcase
  end

  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_opc       <= OPC_NOP;
      r_wdi       <= 8'h00;
      r_rdata     <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      r_ready     <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_DONE);
      r_opc       <= w_opc_nxt;
      r_wdi       <= w_wdi_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

`ifdef PLL_DRP_LOCK_WAIT_EN
  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) begin
      r_commit    <= 1'b0;
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_err       <= 1'b0;
      r_pll_reset <= 1'b0;
    end else begin
      if (w_accept) begin
        r_commit <= bus.req_commit;
      end
      r_lock_meta <= lock;
      r_lock_sync <= r_lock_meta;
      r_cnt       <= w_cnt_nxt;
      r_stable    <= w_stable_nxt;
      if (w_state_nxt == S_DONE) begin
        r_err <= w_timeout;
      end
      r_pll_reset <= (w_state_nxt == S_RST);
    end
  end

  assign bus.rsp_err = r_err;
  assign pll_reset   = r_pll_reset;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{bus.req_commit, lock, RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT};
  assign bus.rsp_err = 1'b0;
  assign pll_reset   = 1'b0;
`endif

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign busy          = r_busy;
  assign mdopc         = r_opc;
  assign mdwdi         = r_wdi;
  assign mdainc        = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_drp_ctrl
// Brief    : Self-checking bench for pll_drp_ctrl (macro PLL_DRP_LOCK_WAIT_EN
//            selects the lock-wait scenarios).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_drp_ctrl;
  localparam int RST_CYCLES   = 8;
  localparam int LOCK_STABLE  = 4;
  localparam int LOCK_TIMEOUT = 65535;

  logic       mdclk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, mdainc, pll_reset;
  logic [1:0] mdopc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo = 8'h00;
  logic       lock  = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  // One sample per cycle after acceptance: {mdopc, mdwdi, rsp_valid, busy, req_ready}
  logic [12:0] trace  [1:5];
  logic [7:0]  rtrace [1:5];
  logic        etrace [1:5];
  logic        ptrace [1:5];

  pll_drp_ctrl_if bus ();

  pll_drp_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .mdclk    (mdclk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .mdopc    (mdopc),
    .mdainc   (mdainc),
    .mdwdi    (mdwdi),
    .mdrdo    (mdrdo),
    .lock     (lock),
    .pll_reset(pll_reset)
  );

  always #5 mdclk = ~mdclk;

  // Reference behaviour: cycle k after the acceptance edge of a plain access.
  function automatic logic [12:0] exp_obs(int k, bit wr, logic [7:0] a, logic [7:0] d);
    int         lat = wr ? 3 : 4;
    logic [1:0] o   = 2'b00;
    logic [7:0] w   = 8'h00;
    if (k == 1) begin
      o = 2'b11; w = a;
    end else if (k == 2) begin
      o = wr ? 2'b01 : 2'b10; w = wr ? d : 8'h00;
    end
    return {o, w, (k == lat), (k <= lat), (k > lat)};
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge mdclk);
    while (!bus.req_ready && n < 100000) begin
      @(negedge mdclk); n++;
    end
    checks++;
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL wait_ready: req_ready=%b required=1 within bound", bus.req_ready);
    end
  endtask

  task automatic accept(input bit wr, input bit cm, input logic [7:0] a, input logic [7:0] d);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_commit = cm;
    bus.req_addr = a; bus.req_wdata = d;
    @(posedge mdclk); #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_commit = 1'($urandom);
    bus.req_addr   = 8'($urandom);
    bus.req_wdata  = 8'($urandom);
  endtask

  task automatic issue(input bit wr, input bit cm, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rd);
    wait_ready();
    accept(wr, cm, a, d);
    for (int k = 1; k <= 5; k++) begin
      mdrdo = (k == 3) ? rd : ~rd;
      @(negedge mdclk);
      trace[k]  = {mdopc, mdwdi, bus.rsp_valid, busy, bus.req_ready};
      rtrace[k] = bus.rsp_rdata;
      etrace[k] = bus.rsp_err;
      ptrace[k] = pll_reset;
      @(posedge mdclk); #1;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_commit = 1'b0;
    bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
    #1 reset = 1'b1;
    repeat (2) @(negedge mdclk);
    checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, mdopc, mdwdi,
         mdainc, pll_reset} !== 24'h0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b rdy=%b rv=%b rdata=%h err=%b opc=%b wdi=%h ainc=%b prst=%b required all 0",
               busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, mdopc, mdwdi, mdainc, pll_reset);
    end
    reset = 1'b0;
    @(negedge mdclk);
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", bus.req_ready, busy);
    end
  endtask

  task automatic test_write_directed();
    issue(1'b1, 1'b0, 8'h12, 8'h64, 8'h5A);
    checks++;
    if (trace[1][12:3] !== {2'b11, 8'h12} || trace[2][12:3] !== {2'b01, 8'h64}) begin
      failures++;
      $display("FAIL write_bus: c1=%h c2=%h required %h %h", trace[1][12:3], trace[2][12:3],
               {2'b11, 8'h12}, {2'b01, 8'h64});
    end
    checks++;
    if (trace[3][2] !== 1'b1 || etrace[3] !== 1'b0 || rtrace[3] !== 8'h00) begin
      failures++;
      $display("FAIL write_rsp: rv=%b err=%b rdata=%h required 1 0 00", trace[3][2], etrace[3], rtrace[3]);
    end
  endtask

  task automatic test_read_directed();
    issue(1'b0, 1'b0, 8'h05, 8'h00, 8'hA7);
    checks++;
    if (trace[2][12:11] !== 2'b10 || trace[3][12:11] !== 2'b00) begin
      failures++;
      $display("FAIL read_opc: c2=%b c3=%b required 10 00", trace[2][12:11], trace[3][12:11]);
    end
    checks++;
    if (trace[4][2] !== 1'b1 || rtrace[4] !== 8'hA7 || rtrace[5] !== 8'hA7) begin
      failures++;
      $display("FAIL read_rsp: rv=%b rdata=%h hold=%h required 1 a7 a7", trace[4][2], rtrace[4], rtrace[5]);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      bit         wr = 1'($urandom);
`ifdef PLL_DRP_LOCK_WAIT_EN
      bit         cm = 1'b0;
`else
      bit         cm = 1'($urandom);
`endif
      logic [7:0] a  = 8'($urandom);
      logic [7:0] d  = 8'($urandom);
      logic [7:0] rd = 8'($urandom);
      int         lat = wr ? 3 : 4;
      issue(wr, cm, a, d, rd);
      for (int k = 1; k <= 5; k++) begin
        checks++;
        if (trace[k] !== exp_obs(k, wr, a, d) || ptrace[k] !== 1'b0 || etrace[k] !== 1'b0) begin
          failures++;
          $display("FAIL random_trace t=%0d k=%0d: got=%h prst=%b err=%b required=%h 0 0",
                   t, k, trace[k], ptrace[k], etrace[k], exp_obs(k, wr, a, d));
        end
      end
      checks++;
      if (rtrace[lat] !== (wr ? 8'h00 : rd)) begin
        failures++;
        $display("FAIL random_rdata t=%0d: got=%h required=%h", t, rtrace[lat], wr ? 8'h00 : rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nrsp = 0;
    logic [7:0] a = 8'($urandom);
    wait_ready();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_commit = 1'b0;
    bus.req_addr = a; bus.req_wdata = ~a;
    for (int n = 1; n <= 16; n++) begin
      @(negedge mdclk);
      nrsp += int'(bus.rsp_valid);
      checks++;
      if (bus.rsp_valid !== (n % 4 == 3) || bus.req_ready !== (n % 4 == 0)) begin
        failures++;
        $display("FAIL back_to_back n=%0d: rv=%b rdy=%b required %b %b", n, bus.rsp_valid,
                 bus.req_ready, (n % 4 == 3), (n % 4 == 0));
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (nrsp != 4) begin
      failures++;
      $display("FAIL back_to_back_count: responses=%0d required=4", nrsp);
    end
  endtask

`ifdef PLL_DRP_LOCK_WAIT_EN
  // Drives a committed write and waits for pll_reset to fall; returns its high time.
  task automatic commit_write(output int high);
    int n = 0;
    high = 0;
    wait_ready();
    accept(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    @(negedge mdclk);
    while (pll_reset !== 1'b1 && n < 20) begin @(negedge mdclk); n++; end
    while (pll_reset === 1'b1 && high < 100) begin high++; @(negedge mdclk); end
  endtask

  task automatic test_lock_success();
    int high, n = 0;
    lock = 1'b0;
    commit_write(high);
    checks++;
    if (high != RST_CYCLES) begin
      failures++;
      $display("FAIL lock_rst_width: pll_reset high=%0d required=%0d", high, RST_CYCLES);
    end
    repeat (19) @(negedge mdclk);
    lock = 1'b1;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge mdclk); n++; end
    checks++;
    if (n != LOCK_STABLE + 2 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL lock_success: cycles=%0d err=%b required %0d 0", n, bus.rsp_err, LOCK_STABLE + 2);
    end
    lock = 1'b0;
  endtask

  task automatic test_lock_timeout();
    int high, n = 1;
    lock = 1'b0;
    commit_write(high);
    while (bus.rsp_valid !== 1'b1 && n < LOCK_TIMEOUT + 20) begin
      if (n == 100 || n == 200 || n == 300) lock = 1'b1;
      if (n == 101 || n == 202 || n == 303) lock = 1'b0;
      @(negedge mdclk); n++;
    end
    checks++;
    if (n != LOCK_TIMEOUT + 1 || bus.rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL lock_timeout: cycle=%0d err=%b required %0d 1", n, bus.rsp_err, LOCK_TIMEOUT + 1);
    end
  endtask
`else
  task automatic test_commit_ignored();
    issue(1'b1, 1'b1, 8'h33, 8'hC4, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (trace[k] !== exp_obs(k, 1'b1, 8'h33, 8'hC4) || ptrace[k] !== 1'b0 || etrace[k] !== 1'b0) begin
        failures++;
        $display("FAIL commit_ignored k=%0d: got=%h prst=%b err=%b required=%h 0 0",
                 k, trace[k], ptrace[k], etrace[k], exp_obs(k, 1'b1, 8'h33, 8'hC4));
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int nrv = 0;
`ifdef PLL_DRP_LOCK_WAIT_EN
    int high;
    lock = 1'b0;
    commit_write(high);
    repeat (5) @(negedge mdclk);
`else
    wait_ready();
    accept(1'b0, 1'b0, 8'h41, 8'h00);
`endif
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, mdopc, mdwdi, pll_reset} !== 23'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b rdy=%b rv=%b rdata=%h err=%b opc=%b wdi=%h prst=%b required all 0",
               busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, mdopc, mdwdi, pll_reset);
    end
    @(negedge mdclk);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge mdclk);
      nrv += int'(bus.rsp_valid);
    end
    checks++;
    if (nrv != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_norsp: responses=%0d busy=%b required 0 0", nrv, busy);
    end
    issue(1'b0, 1'b0, 8'h05, 8'h00, 8'h3C);
    checks++;
    if (trace[4][2] !== 1'b1 || rtrace[4] !== 8'h3C) begin
      failures++;
      $display("FAIL reset_mid_read: rv=%b rdata=%h required 1 3c", trace[4][2], rtrace[4]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_directed();
    test_read_directed();
    test_random();
    test_back_to_back();
`ifdef PLL_DRP_LOCK_WAIT_EN
    test_lock_success();
    test_lock_timeout();
`else
    test_commit_ignored();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
